// File: rtl/credit_bcd_converter.sv
// Binary-to-BCD converter for the won/credit display: clamps both totals, runs two
// double-dabble engines in lockstep, and publishes all digits at once on done.

module dd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// One shift-add-3 engine; NDIG digits of scratch, BIN_W bits of binary shifted in MSB first.
module dd_engine #(
  parameter int BIN_W = 10,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic                step,
  input  logic [BIN_W-1:0]    bin,
  output logic [NDIG*4-1:0]   bcd
);
  logic [BIN_W-1:0]  sr;
  logic [NDIG*4-1:0] bcd_q;
  logic [NDIG*4-1:0] adj;

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_dig
      dd_digit_adj u_adj (.d(bcd_q[g*4 +: 4]), .q(adj[g*4 +: 4]));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q <= '0;
      sr    <= '0;
    end else if (init) begin
      bcd_q <= '0;
      sr    <= bin;
    end else if (step) begin
      {bcd_q, sr} <= {adj, sr} << 1;
    end
  end

  assign bcd = bcd_q;
endmodule

module credit_bcd_converter #(
  parameter int WON_MAX    = 99,
  parameter int CREDIT_MAX = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [6:0] won_bin,
  input  logic [9:0] credit_bin,
  output logic       busy,
  output logic       done,
  output logic       sat,
  output logic [3:0] won_amt1,
  output logic [3:0] won_amt2,
  output logic [3:0] credit_amt1,
  output logic [3:0] credit_amt2,
  output logic [3:0] credit_amt3
);
  localparam int ITERS = 10;

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        sat_next;
  logic        init;
  logic        step;
  logic        won_over;
  logic        cred_over;
  logic [6:0]  won_c;
  logic [9:0]  cred_c;
  logic [7:0]  won_bcd;
  logic [11:0] cred_bcd;

  assign won_over  = won_bin > 7'(WON_MAX);
  assign cred_over = credit_bin > 10'(CREDIT_MAX);
  assign won_c     = won_over  ? 7'(WON_MAX)     : won_bin;
  assign cred_c    = cred_over ? 10'(CREDIT_MAX) : credit_bin;

  assign init = (state == IDLE) && load;
  assign step = (state == CONV);

  dd_engine #(.BIN_W(10), .NDIG(2)) u_won (
    .clk(clk), .reset(reset), .init(init), .step(step),
    .bin({3'b000, won_c}), .bcd(won_bcd)
  );

  dd_engine #(.BIN_W(10), .NDIG(3)) u_cred (
    .clk(clk), .reset(reset), .init(init), .step(step),
    .bin(cred_c), .bcd(cred_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sat_next    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sat         <= 1'b0;
      won_amt1    <= '0;
      won_amt2    <= '0;
      credit_amt1 <= '0;
      credit_amt2 <= '0;
      credit_amt3 <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            sat_next <= won_over | cred_over;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(ITERS - 1)) state <= FINISH;
        end
        FINISH: begin
          // all five digits and sat move on the same edge so the mux never sees a mix
          won_amt1    <= won_bcd[7:4];
          won_amt2    <= won_bcd[3:0];
          credit_amt1 <= cred_bcd[11:8];
          credit_amt2 <= cred_bcd[7:4];
          credit_amt3 <= cred_bcd[3:0];
          sat         <= sat_next;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_credit_bcd_converter.sv
// Bench for credit_bcd_converter: a cycle-count/arithmetic model checked every cycle,
// plus directed scenarios with literal expectations and a randomized soak.

module tb_credit_bcd_converter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [6:0] won_bin = '0;
  logic [9:0] credit_bin = '0;
  logic       busy, done, sat;
  logic [3:0] won_amt1, won_amt2, credit_amt1, credit_amt2, credit_amt3;

  int ncmp = 0;
  int nbad = 0;

  credit_bcd_converter #(.WON_MAX(99), .CREDIT_MAX(999)) dut (
    .clk(clk), .reset(reset), .load(load), .won_bin(won_bin), .credit_bin(credit_bin),
    .busy(busy), .done(done), .sat(sat),
    .won_amt1(won_amt1), .won_amt2(won_amt2),
    .credit_amt1(credit_amt1), .credit_amt2(credit_amt2), .credit_amt3(credit_amt3)
  );

  always #5 clk = ~clk;

  // Model: a conversion is just "remaining cycles"; digits come from / and %.
  int         m_rem = 0;
  logic       m_busy = 0, m_done = 0, m_sat = 0, m_sat_n = 0;
  int         m_w = 0, m_c = 0;
  logic [3:0] m_d [5] = '{default: 4'd0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem <= 0; m_busy <= 0; m_done <= 0; m_sat <= 0; m_sat_n <= 0;
      m_w <= 0; m_c <= 0;
      for (int i = 0; i < 5; i++) m_d[i] <= 4'd0;
    end else begin
      m_done <= 0;
      if (m_rem == 0) begin
        if (load) begin
          m_rem   <= 11;
          m_busy  <= 1;
          m_w     <= (int'(won_bin) > 99) ? 99 : int'(won_bin);
          m_c     <= (int'(credit_bin) > 999) ? 999 : int'(credit_bin);
          m_sat_n <= (int'(won_bin) > 99) || (int'(credit_bin) > 999);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_busy <= 0;
          m_done <= 1;
          m_sat  <= m_sat_n;
          m_d[0] <= 4'(m_w / 10);
          m_d[1] <= 4'(m_w % 10);
          m_d[2] <= 4'(m_c / 100);
          m_d[3] <= 4'((m_c / 10) % 10);
          m_d[4] <= 4'(m_c % 10);
        end
      end
    end
  end

  always @(negedge clk) begin
    ncmp++;
    if ({busy, done, sat} !== {m_busy, m_done, m_sat}) begin
      nbad++;
      $display("FAIL ctrl t=%0t busy/done/sat got=%b%b%b exp=%b%b%b", $time,
               busy, done, sat, m_busy, m_done, m_sat);
    end
    ncmp++;
    if ({won_amt1, won_amt2, credit_amt1, credit_amt2, credit_amt3} !==
        {m_d[0], m_d[1], m_d[2], m_d[3], m_d[4]}) begin
      nbad++;
      $display("FAIL digits t=%0t got=%h%h/%h%h%h exp=%h%h/%h%h%h", $time,
               won_amt1, won_amt2, credit_amt1, credit_amt2, credit_amt3,
               m_d[0], m_d[1], m_d[2], m_d[3], m_d[4]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic chk_dig(input string name, input int w, input int c, input int s);
    chk({name, "_won"}, int'({won_amt1, won_amt2}), int'({4'(w / 10), 4'(w % 10)}));
    chk({name, "_cred"}, int'({credit_amt1, credit_amt2, credit_amt3}),
        int'({4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)}));
    chk({name, "_sat"}, int'(sat), s);
  endtask

  int bcnt;

  // Drives a one-cycle load; leaves the bench just after edge 0.
  task automatic pulse(input int c, input int w);
    credit_bin = 10'(c); won_bin = 7'(w); load = 1;
    cyc();
    load = 0;
    bcnt = busy ? 1 : 0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      cycles++;
      if (done) ok = 1;
      else if (busy) bcnt++;
    end
    chk({name, "_done_seen"}, int'(ok), 1);
  endtask

  task automatic count_dones(input string name, input int n);
    int d = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (done) d++;
    end
    chk({name, "_no_done"}, d, 0);
  endtask

  initial begin
    int cy, changes;
    #1 reset = 1;
    for (int i = 0; i < 3; i++) begin
      load = ~load; credit_bin = 10'(437); won_bin = 7'(25);
      cyc();
      chk("reset_out", int'({busy, done, sat, won_amt1, won_amt2, credit_amt1, credit_amt2, credit_amt3}), 0);
    end
    load = 0; reset = 0;
    cyc();

    // Nominal
    pulse(437, 25);
    wait_done("nom", cy);
    chk("nom_busy_cycles", bcnt, 11);
    chk("nom_latency", cy, 11);
    chk_dig("nom", 25, 437, 0);
    chk("nom_lit_cred", int'({credit_amt1, credit_amt2, credit_amt3}), 12'h437);
    chk("nom_lit_won", int'({won_amt1, won_amt2}), 8'h25);
    cyc();
    chk("nom_done_one_cycle", int'(done), 0);

    // Saturation then zero
    pulse(1023, 127);
    wait_done("satr", cy);
    chk("sat_lit", int'({credit_amt1, credit_amt2, credit_amt3, won_amt1, won_amt2, sat}), {20'h99999, 1'b1});
    pulse(0, 0);
    wait_done("zero", cy);
    chk_dig("zero", 0, 0, 0);

    // Load while busy is dropped
    pulse(100, 10);
    repeat (4) cyc();
    pulse(555, 55);
    wait_done("lwb", cy);
    chk("lwb_lit", int'({credit_amt1, credit_amt2, credit_amt3, won_amt1, won_amt2}), 20'h10010);
    count_dones("lwb", 20);

    // Back-to-back with load held high
    credit_bin = 10'(999); won_bin = 7'(99); load = 1;
    wait_done("b2b1", cy);
    chk_dig("b2b1", 99, 999, 0);
    credit_bin = 10'(500); won_bin = 7'(9);
    changes = 0;
    cy = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      cy++;
      if (done) break;
      if ({credit_amt1, credit_amt2, credit_amt3, won_amt1, won_amt2} !== 20'h99999) changes++;
    end
    load = 0;
    chk("b2b_period", cy, 12);
    chk("b2b_stable", changes, 0);
    chk("b2b2_lit", int'({credit_amt1, credit_amt2, credit_amt3, won_amt1, won_amt2}), 20'h50009);

    // Reset mid-conversion
    pulse(321, 12);
    repeat (5) cyc();
    @(posedge clk); #2 reset = 1;
    #1 chk("mid_reset_async", int'({busy, done, sat, won_amt1, won_amt2, credit_amt1, credit_amt2, credit_amt3}), 0);
    cyc();
    reset = 0;
    count_dones("abort", 15);
    pulse(7, 3);
    wait_done("post_reset", cy);
    chk("post_reset_lit", int'({credit_amt1, credit_amt2, credit_amt3, won_amt1, won_amt2}), 20'h00703);

    // Random soak: the per-cycle compare carries the checking
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 3) == 0);
      credit_bin = 10'($urandom);
      won_bin = 7'($urandom);
      if ($urandom_range(0, 1) == 0) credit_bin = 10'($urandom_range(990, 1010));
      cyc();
    end
    load = 0;
    repeat (15) cyc();

    $display("test done: total=%0d bad=%0d", ncmp, nbad);
    $finish;
  end
endmodule
